// File: rtl/backprop_sequencer.sv
// backprop_sequencer: steps one neuron's synapses through a shared back-prop unit.
// Define BPS_WEIGHT_CLAMP_EN to saturate each committed weight to [-W_LIMIT, +W_LIMIT].
module backprop_sequencer #(
  parameter int  N_INPUTS = 4,
  parameter int  IDX_W    = 2,
  parameter real W_LIMIT  = 8.0
) (
  input  logic             bps_clk,
  input  logic             bps_rst_n,
  input  logic             bps_start,
  input  real              bps_axon,
  input  real              bps_back_prop,
  input  real              bps_ratio,
  input  logic             bps_prev_wr_en,
  input  logic [IDX_W-1:0] bps_prev_wr_idx,
  input  real              bps_prev_wr_data,
  input  logic             bps_w_wr_en,
  input  logic [IDX_W-1:0] bps_w_wr_idx,
  input  real              bps_w_wr_data,
  input  logic [IDX_W-1:0] bps_w_rd_idx,
  output real              bps_w_rd_data,
  output real              bps_bp_previous,
  output real              bps_bp_weight,
  output real              bps_bp_axon,
  output real              bps_bp_back_prop,
  output real              bps_bp_ratio,
  input  real              bps_bp_back_prop_new,
  input  real              bps_bp_weight_new,
  output logic             bps_out_valid,
  input  logic             bps_out_ready,
  output logic [IDX_W-1:0] bps_out_idx,
  output real              bps_out_back_prop,
  output logic             bps_busy,
  output logic             bps_done
);
`ifdef BPS_WEIGHT_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  real              w_q [N_INPUTS];
  real              prev_q [N_INPUTS];
  real              axon_q, bp_q, ratio_q;
  real              bpn_q, wn_q, wn_commit;
  real              h_prev_q, h_w_q, h_axon_q, h_bp_q, h_ratio_q;
  logic             idle, calc, last, handshake, w_wr_ok, p_wr_ok;
  assign idle      = state_q == IDLE;
  assign calc      = state_q == CALC;
  assign last      = int'(idx_q) == N_INPUTS - 1;
  assign handshake = state_q == OUT && bps_out_ready;
  assign w_wr_ok   = idle && bps_w_wr_en && int'(bps_w_wr_idx) < N_INPUTS;
  assign p_wr_ok   = idle && bps_prev_wr_en && int'(bps_prev_wr_idx) < N_INPUTS;
  assign bps_w_rd_data     = int'(bps_w_rd_idx) < N_INPUTS ? w_q[bps_w_rd_idx] : 0.0;
  assign bps_bp_previous   = calc ? prev_q[idx_q] : h_prev_q;
  assign bps_bp_weight     = calc ? w_q[idx_q] : h_w_q;
  assign bps_bp_axon       = calc ? axon_q : h_axon_q;
  assign bps_bp_back_prop  = calc ? bp_q : h_bp_q;
  assign bps_bp_ratio      = calc ? ratio_q : h_ratio_q;
  assign bps_out_valid     = state_q == OUT;
  assign bps_out_idx       = idx_q;
  assign bps_out_back_prop = bpn_q;
  assign bps_busy          = !idle;
  assign bps_done          = state_q == DONE;
  // Weight to commit on handshake, optionally saturated.
  always_comb begin
    wn_commit = wn_q;
    if (CLAMP_EN && wn_q > W_LIMIT) wn_commit = W_LIMIT;
    if (CLAMP_EN && wn_q < -W_LIMIT) wn_commit = -W_LIMIT;
  end
  // Next state and synapse index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bps_start) begin
        state_d = CALC;
        idx_d   = '0;
      end
      CALC: state_d = OUT;
      OUT: if (bps_out_ready) begin
        state_d = last ? DONE : CALC;
        idx_d   = last ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state register.
  always_ff @(posedge bps_clk or negedge bps_rst_n) begin
    if (!bps_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // Operand latches, unit result capture, held unit operands and the weight/activation stores.
  always_ff @(posedge bps_clk or negedge bps_rst_n) begin
    if (!bps_rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i]    <= 0.0;
        prev_q[i] <= 0.0;
      end
      axon_q    <= 0.0;
      bp_q      <= 0.0;
      ratio_q   <= 0.0;
      bpn_q     <= 0.0;
      wn_q      <= 0.0;
      h_prev_q  <= 0.0;
      h_w_q     <= 0.0;
      h_axon_q  <= 0.0;
      h_bp_q    <= 0.0;
      h_ratio_q <= 0.0;
    end else begin
      if (idle && bps_start) begin
        axon_q  <= bps_axon;
        bp_q    <= bps_back_prop;
        ratio_q <= bps_ratio;
      end
      if (calc) begin
        bpn_q     <= bps_bp_back_prop_new;
        wn_q      <= bps_bp_weight_new;
        h_prev_q  <= bps_bp_previous;
        h_w_q     <= bps_bp_weight;
        h_axon_q  <= bps_bp_axon;
        h_bp_q    <= bps_bp_back_prop;
        h_ratio_q <= bps_bp_ratio;
      end
      if (w_wr_ok) w_q[bps_w_wr_idx] <= bps_w_wr_data;
      if (p_wr_ok) prev_q[bps_prev_wr_idx] <= bps_prev_wr_data;
      if (handshake) w_q[idx_q] <= wn_commit;
    end
  end
endmodule

// File: tb/tb_backprop_sequencer.sv
// tb_backprop_sequencer: randomized passes of backprop_sequencer checked against an arithmetic model.
module tb_backprop_sequencer;
  logic       clk = 0, rst_n = 0, start = 0, pw_en = 0, ww_en = 0, ready = 1;
  logic [1:0] pw_idx = 0, ww_idx = 0, rd_idx = 0;
  real        axon = 0.0, bp = 0.0, ratio = 0.0, pw_data = 0.0, ww_data = 0.0;
  real        rd_data, bp_prev, bp_w, bp_ax, bp_bp, bp_r, u_bpn, u_wn, out_bp;
  logic       valid, busy, done;
  logic [1:0] out_idx;
  int         tests = 0, fails = 0;
  real        m_w [4], m_p [4];
  backprop_sequencer dut (
    .bps_clk(clk), .bps_rst_n(rst_n), .bps_start(start),
    .bps_axon(axon), .bps_back_prop(bp), .bps_ratio(ratio),
    .bps_prev_wr_en(pw_en), .bps_prev_wr_idx(pw_idx), .bps_prev_wr_data(pw_data),
    .bps_w_wr_en(ww_en), .bps_w_wr_idx(ww_idx), .bps_w_wr_data(ww_data),
    .bps_w_rd_idx(rd_idx), .bps_w_rd_data(rd_data),
    .bps_bp_previous(bp_prev), .bps_bp_weight(bp_w), .bps_bp_axon(bp_ax),
    .bps_bp_back_prop(bp_bp), .bps_bp_ratio(bp_r),
    .bps_bp_back_prop_new(u_bpn), .bps_bp_weight_new(u_wn),
    .bps_out_valid(valid), .bps_out_ready(ready), .bps_out_idx(out_idx),
    .bps_out_back_prop(out_bp), .bps_busy(busy), .bps_done(done)
  );
  always #5 clk = ~clk;
  // External per-synapse back-prop unit: sigmoid-derivative error and weight update.
  always_comb begin
    u_bpn = bp_w * bp_bp * bp_ax * (1.0 - bp_ax);
    u_wn  = bp_w + bp_r * bp_bp * bp_prev * bp_ax * (1.0 - bp_ax);
  end
  task automatic check(input string tag, input real got, input real exp);
    tests++;
    if (got - exp > 1e-9 || exp - got > 1e-9) begin
      fails++;
      $display("FAIL %s: got %0g expected %0g", tag, got, exp);
    end
  endtask
  function automatic real clampw(input real v);
`ifdef BPS_WEIGHT_CLAMP_EN
    return v > 8.0 ? 8.0 : (v < -8.0 ? -8.0 : v);
`else
    return v;
`endif
  endfunction
  function automatic real rnd(input real lo, input real hi);
    return lo + (hi - lo) * real'($urandom_range(0, 1000)) / 1000.0;
  endfunction
  task automatic wr_w(input int i, input real v);
    ww_en = 1; ww_idx = 2'(i); ww_data = v;
    @(posedge clk); #1;
    ww_en = 0;
    m_w[i] = v;
  endtask
  task automatic wr_p(input int i, input real v);
    pw_en = 1; pw_idx = 2'(i); pw_data = v;
    @(posedge clk); #1;
    pw_en = 0;
    m_p[i] = v;
  endtask
  task automatic check_weights(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1 check(tag, rd_data, m_w[i]);
    end
  endtask
  task automatic run_pass(input real a, input real b, input real r, input int stall_idx,
                          input int stall_len, input bit rand_stall, input bit wr_during,
                          input bit poke, input bit sim_wr);
    real e_bp [4], e_w [4];
    int  cyc, len;
    bit  stalled;
    stalled = 0;
    if (sim_wr) begin
      ww_en = 1; ww_idx = 0; ww_data = -1.5; m_w[0] = -1.5;
    end
    for (int i = 0; i < 4; i++) begin
      e_bp[i] = m_w[i] * b * a * (1.0 - a);
      e_w[i]  = clampw(m_w[i] + r * b * m_p[i] * a * (1.0 - a));
    end
    axon = a; bp = b; ratio = r; start = 1; ready = 1;
    @(posedge clk); #1;
    start = 0; ww_en = 0; cyc = 1;
    axon = 0.77; bp = -3.3; ratio = 5.5;
    check("busy_start", busy, 1);
    for (int k = 0; k < 4; k++) begin
      while (!valid && cyc < 100) begin
        @(posedge clk); #1; cyc++;
      end
      check("valid", valid, 1);
      check("out_idx", out_idx, k);
      check("out_bp", out_bp, e_bp[k]);
      len = k == stall_idx ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      if (len > 0) begin
        stalled = 1; ready = 0; rd_idx = 2'(k);
        repeat (len) begin
          @(posedge clk); #1; cyc++;
          check("stall_valid", valid, 1);
          check("stall_idx", out_idx, k);
          check("stall_bp", out_bp, e_bp[k]);
          check("stall_w", rd_data, m_w[k]);
        end
        ready = 1;
      end
      if (wr_during && k == 1) begin
        ww_en = 1; ww_idx = 2; ww_data = 7.0;
        pw_en = 1; pw_idx = 0; pw_data = 9.0;
      end
      if (poke && k == 0) start = 1;
      @(posedge clk); #1; cyc++;
      ww_en = 0; pw_en = 0; start = 0;
    end
    check("done", done, 1);
    if (!stalled) check("latency", cyc, 9);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
    for (int i = 0; i < 4; i++) m_w[i] = e_w[i];
    check_weights("weight");
  endtask
  task automatic reset_mid_pass();
    int n;
    axon = 0.5; bp = 1.0; ratio = 0.1; start = 1;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (!(valid && out_idx == 2) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("rst_reach_idx2", out_idx, 2);
    #2 rst_n = 0;
    #1 check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_bp_prev", bp_prev, 0.0);
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 0.0; m_p[i] = 0.0;
    end
    check_weights("rst_w");
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end
    @(negedge clk) rst_n = 1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_idle_done", done, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 0.0; m_p[i] = 0.0;
    end
    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_done", done, 0);
    check("reset_idx", out_idx, 0);
    check_weights("reset_w");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wr_w(i, 2.0);
    for (int i = 0; i < 4; i++) wr_p(i, 1.0);
    run_pass(0.5, 1.0, 0.1, -1, 0, 0, 0, 0, 0);
    check("pass1_w0", m_w[0], 2.025);
    run_pass(0.5, 1.0, 0.1, 1, 5, 0, 0, 0, 0);
    run_pass(0.25, 2.0, 0.2, -1, 0, 0, 1, 1, 0);
    rd_idx = 2;
    #1 check("drop_wr_not_7", rd_data == 7.0 ? 1.0 : 0.0, 0.0);
    repeat (6) begin
      for (int i = 0; i < 4; i++) wr_w(i, rnd(-4.0, 4.0));
      for (int i = 0; i < 4; i++) wr_p(i, rnd(-2.0, 2.0));
      run_pass(rnd(0.0, 1.0), rnd(-2.0, 2.0), rnd(0.0, 0.5), -1, 0, 1, 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    reset_mid_pass();
    for (int i = 0; i < 4; i++) wr_p(i, 1.5);
    run_pass(0.5, 1.0, 0.5, -1, 0, 0, 0, 0, 1);
    wr_w(0, 7.99);
    for (int i = 1; i < 4; i++) wr_w(i, 1.0);
    for (int i = 0; i < 4; i++) wr_p(i, 10.0);
    run_pass(0.5, 4.0, 1.0, -1, 0, 0, 0, 0, 0);
    rd_idx = 0;
`ifdef BPS_WEIGHT_CLAMP_EN
    #1 check("clamp_w0", rd_data, 8.0);
`else
    #1 check("clamp_w0", rd_data, 17.99);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
